// File: rtl/lcd_page_scheduler.sv
// Chooses the 32-char frame shown on a 16x2 LCD: two rotating status pages plus a preempting rain alert.
// Optional build macro ALERT_BLINK_EN makes the alert frame blink against spaces.
module lcd_page_scheduler #(
  parameter int unsigned INIT_CYCLES       = 1000,
  parameter int unsigned DWELL_CYCLES      = 100_000_000,
  parameter int unsigned REFRESH_CYCLES    = 5_000_000,
  parameter int unsigned ALERT_HOLD_CYCLES = 250_000_000,
  parameter int unsigned BLINK_CYCLES      = 25_000_000
) (
  input  logic         iCLK_50MHZ,
  input  logic         iRST_N,
  input  logic [255:0] page0_frame,
  input  logic [255:0] page1_frame,
  input  logic [255:0] alert_frame,
  input  logic         alert_req,
  input  logic         hold,
  output logic [127:0] line1,
  output logic [127:0] line2,
  output logic         frame_valid,
  output logic [1:0]   active_src
);

  typedef enum logic [1:0] {ST_INIT, ST_SHOW_P0, ST_SHOW_P1, ST_SHOW_ALERT} state_t;
  typedef enum logic [1:0] {SRC_P0 = 2'd0, SRC_P1 = 2'd1, SRC_ALERT = 2'd2, SRC_BLANK = 2'd3} src_t;

  localparam logic [31:0]  INIT_LAST    = 32'(INIT_CYCLES - 1);
  localparam logic [31:0]  DWELL_LAST   = 32'(DWELL_CYCLES - 1);
  localparam logic [31:0]  REFRESH_LAST = 32'(REFRESH_CYCLES - 1);
  localparam logic [31:0]  HOLD_LAST    = 32'(ALERT_HOLD_CYCLES - 1);
  localparam logic [127:0] BLANK_LINE   = {16{8'h20}};

  // Every timing parameter must be at least one cycle.
  if (INIT_CYCLES < 1 || DWELL_CYCLES < 1 || REFRESH_CYCLES < 1 ||
      ALERT_HOLD_CYCLES < 1 || BLINK_CYCLES < 1) begin : g_bad_param
    $error("lcd_page_scheduler: all cycle parameters must be >= 1");
  end

  state_t       state_q, state_d;
  logic [31:0]  init_cnt_q, init_cnt_d;
  logic [31:0]  dwell_q, dwell_d;
  logic [31:0]  refresh_q, refresh_d;
  logic [31:0]  alert_cnt_q, alert_cnt_d;
  logic         saved_p1_q, saved_p1_d;
  logic         load;
  src_t         load_src;
  logic         load_blank;
  logic [255:0] load_frame;

`ifdef ALERT_BLINK_EN
  localparam logic [31:0] BLINK_LAST = 32'(BLINK_CYCLES - 1);
  logic [31:0] blink_cnt_q, blink_cnt_d;
  logic        blink_on_q, blink_on_d;
`endif

  // NOTE: every signal written here gets a default first, so no path leaves one
  // unassigned and no latch is inferred.
  always_comb begin
    state_d     = state_q;
    init_cnt_d  = init_cnt_q;
    dwell_d     = dwell_q;
    alert_cnt_d = alert_cnt_q;
    saved_p1_d  = saved_p1_q;
    load        = 1'b0;
    load_src    = SRC_BLANK;
    load_blank  = 1'b0;
`ifdef ALERT_BLINK_EN
    blink_cnt_d = blink_cnt_q;
    blink_on_d  = blink_on_q;
`endif

    case (state_q)
      ST_INIT: begin
        if (init_cnt_q == INIT_LAST) begin
          load = 1'b1;
          if (alert_req) begin
            load_src    = SRC_ALERT;
            state_d     = ST_SHOW_ALERT;
            alert_cnt_d = '0;
          end else begin
            load_src = SRC_P0;
            state_d  = ST_SHOW_P0;
            dwell_d  = '0;
          end
        end else begin
          init_cnt_d = init_cnt_q + 32'd1;
        end
      end

      ST_SHOW_P0, ST_SHOW_P1: begin
        if (alert_req) begin
          load        = 1'b1;
          load_src    = SRC_ALERT;
          saved_p1_d  = (state_q == ST_SHOW_P1);
          state_d     = ST_SHOW_ALERT;
          alert_cnt_d = '0;
        end else if (dwell_q == DWELL_LAST && !hold) begin
          // A switch also covers a coincident refresh: one load only.
          load     = 1'b1;
          load_src = (state_q == ST_SHOW_P1) ? SRC_P0 : SRC_P1;
          state_d  = (state_q == ST_SHOW_P1) ? ST_SHOW_P0 : ST_SHOW_P1;
          dwell_d  = '0;
        end else begin
          if (dwell_q != DWELL_LAST) dwell_d = dwell_q + 32'd1;
          if (refresh_q == REFRESH_LAST) begin
            load     = 1'b1;
            load_src = (state_q == ST_SHOW_P1) ? SRC_P1 : SRC_P0;
          end
        end
      end

      ST_SHOW_ALERT: begin
        if (alert_req) begin
          alert_cnt_d = '0;
        end else if (alert_cnt_q == HOLD_LAST) begin
          load        = 1'b1;
          load_src    = saved_p1_q ? SRC_P1 : SRC_P0;
          state_d     = saved_p1_q ? ST_SHOW_P1 : ST_SHOW_P0;
          dwell_d     = '0;
          alert_cnt_d = '0;
        end else begin
          alert_cnt_d = alert_cnt_q + 32'd1;
        end

        if (!load) begin
`ifdef ALERT_BLINK_EN
          if (blink_cnt_q == BLINK_LAST) begin
            blink_cnt_d = '0;
            blink_on_d  = !blink_on_q;
            load        = 1'b1;
            load_src    = SRC_ALERT;
            load_blank  = blink_on_q;
          end else begin
            blink_cnt_d = blink_cnt_q + 32'd1;
            if (refresh_q == REFRESH_LAST) begin
              load       = 1'b1;
              load_src   = SRC_ALERT;
              load_blank = !blink_on_q;
            end
          end
`else
          if (refresh_q == REFRESH_LAST) begin
            load     = 1'b1;
            load_src = SRC_ALERT;
          end
`endif
        end
      end

      default: state_d = ST_INIT;
    endcase

    refresh_d = (load || state_q == ST_INIT) ? '0 : refresh_q + 32'd1;
  end

  always_comb begin
    load_frame = {BLANK_LINE, BLANK_LINE};
    case (load_src)
      SRC_P0:    load_frame = page0_frame;
      SRC_P1:    load_frame = page1_frame;
      SRC_ALERT: load_frame = load_blank ? {BLANK_LINE, BLANK_LINE} : alert_frame;
      default:   load_frame = {BLANK_LINE, BLANK_LINE};
    endcase
  end

  // NOTE: state is only ever updated with non-blocking assignments so every
  // register samples the values from before the edge.
  always_ff @(posedge iCLK_50MHZ or negedge iRST_N) begin
    if (!iRST_N) begin
      state_q     <= ST_INIT;
      init_cnt_q  <= '0;
      dwell_q     <= '0;
      refresh_q   <= '0;
      alert_cnt_q <= '0;
      saved_p1_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      init_cnt_q  <= init_cnt_d;
      dwell_q     <= dwell_d;
      refresh_q   <= refresh_d;
      alert_cnt_q <= alert_cnt_d;
      saved_p1_q  <= saved_p1_d;
    end
  end

`ifdef ALERT_BLINK_EN
  // Outside the alert the blink phase is parked, so each alert entry starts "on".
  always_ff @(posedge iCLK_50MHZ or negedge iRST_N) begin
    if (!iRST_N) begin
      blink_cnt_q <= '0;
      blink_on_q  <= 1'b1;
    end else if (state_q != ST_SHOW_ALERT) begin
      blink_cnt_q <= '0;
      blink_on_q  <= 1'b1;
    end else begin
      blink_cnt_q <= blink_cnt_d;
      blink_on_q  <= blink_on_d;
    end
  end
`endif

  always_ff @(posedge iCLK_50MHZ or negedge iRST_N) begin
    if (!iRST_N) begin
      line1       <= BLANK_LINE;
      line2       <= BLANK_LINE;
      frame_valid <= 1'b0;
      active_src  <= SRC_BLANK;
    end else begin
      frame_valid <= load;
      if (load) begin
        {line1, line2} <= load_frame;
        active_src     <= load_src;
      end
    end
  end

endmodule

// File: tb/tb_lcd_page_scheduler.sv
// Directed bench for lcd_page_scheduler with INIT=4, DWELL=8, REFRESH=5, ALERT_HOLD=6, BLINK=3.
// Time t counts clock edges from the first page load (t=0); outputs are sampled 1 ns after each edge.
module tb_lcd_page_scheduler;

  localparam logic [255:0] P0A   = {"PAGE ZERO LINE 1", "page zero line 2"};
  localparam logic [255:0] P0B   = {"PAGE ZERO REV B ", "page zero rev b "};
  localparam logic [255:0] P1    = {"PAGE ONE LINE 1 ", "page one line 2 "};
  localparam logic [255:0] ALERT = {"!! RAIN ALERT !!", "close the window"};
  localparam logic [255:0] BLANK = {32{8'h20}};

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [255:0] page0_frame = P0A;
  logic [255:0] page1_frame = P1;
  logic [255:0] alert_frame = ALERT;
  logic         alert_req = 1'b0;
  logic         hold = 1'b0;
  logic [127:0] line1, line2;
  logic         frame_valid;
  logic [1:0]   active_src;

  int vectors = 0;
  int fails   = 0;
  int t       = 0;

  always #5 clk = ~clk;

  lcd_page_scheduler #(
    .INIT_CYCLES      (4),
    .DWELL_CYCLES     (8),
    .REFRESH_CYCLES   (5),
    .ALERT_HOLD_CYCLES(6),
    .BLINK_CYCLES     (3)
  ) dut (
    .iCLK_50MHZ (clk),
    .iRST_N     (rst_n),
    .page0_frame(page0_frame),
    .page1_frame(page1_frame),
    .alert_frame(alert_frame),
    .alert_req  (alert_req),
    .hold       (hold),
    .line1      (line1),
    .line2      (line2),
    .frame_valid(frame_valid),
    .active_src (active_src)
  );

  task automatic tick();
    @(posedge clk);
    #1;
    t++;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) tick();
    vectors++;
    if ({line1, line2} !== BLANK) begin
      fails++;
      $display("FAIL reset_lines got %h want %h", {line1, line2}, BLANK);
    end
    vectors++;
    if (frame_valid !== 1'b0 || active_src !== 2'd3) begin
      fails++;
      $display("FAIL reset_ctrl got fv=%b src=%0d want fv=0 src=3", frame_valid, active_src);
    end
    rst_n = 1'b1;
    for (int k = 1; k <= 3; k++) begin
      tick();
      vectors++;
      if (frame_valid !== 1'b0 || active_src !== 2'd3) begin
        fails++;
        $display("FAIL init_wait edge=%0d got fv=%b src=%0d want fv=0 src=3", k, frame_valid, active_src);
      end
    end
    tick();
    vectors++;
    if (frame_valid !== 1'b1 || active_src !== 2'd0) begin
      fails++;
      $display("FAIL first_load got fv=%b src=%0d want fv=1 src=0", frame_valid, active_src);
    end
    vectors++;
    if ({line1, line2} !== P0A) begin
      fails++;
      $display("FAIL first_frame got %h want %h", {line1, line2}, P0A);
    end
    t = 0;
  endtask

  task automatic test_free_run();
    logic         exp_fv;
    logic [1:0]   exp_src;
    logic [255:0] exp_frame;
    for (int i = 1; i <= 24; i++) begin
      tick();
      exp_fv  = (t inside {5, 8, 13, 16, 21, 24});
      exp_src = ((t >= 8 && t < 16) || t == 24) ? 2'd1 : 2'd0;
      vectors++;
      if (frame_valid !== exp_fv || active_src !== exp_src) begin
        fails++;
        $display("FAIL free_run t=%0d got fv=%b src=%0d want fv=%b src=%0d",
                 t, frame_valid, active_src, exp_fv, exp_src);
      end
      // Page 0 content changes mid-dwell; it must only appear at the next load.
      if (t == 2) page0_frame = P0B;
      if (t inside {3, 5, 8, 16}) begin
        exp_frame = (t == 3) ? P0A : (t == 8) ? P1 : P0B;
        vectors++;
        if ({line1, line2} !== exp_frame) begin
          fails++;
          $display("FAIL free_run_frame t=%0d got %h want %h", t, {line1, line2}, exp_frame);
        end
      end
    end
  endtask

  task automatic test_hold();
    logic exp_fv;
    hold = 1'b1;
    for (int i = 25; i <= 44; i++) begin
      tick();
      exp_fv = (t inside {29, 34, 39, 44});
      vectors++;
      if (frame_valid !== exp_fv || active_src !== 2'd1) begin
        fails++;
        $display("FAIL hold t=%0d got fv=%b src=%0d want fv=%b src=1", t, frame_valid, active_src, exp_fv);
      end
    end
    hold = 1'b0;
    tick();
    vectors++;
    if (frame_valid !== 1'b1 || active_src !== 2'd0 || {line1, line2} !== P0B) begin
      fails++;
      $display("FAIL hold_release t=%0d got fv=%b src=%0d want fv=1 src=0 page0", t, frame_valid, active_src);
    end
  endtask

  task automatic test_alert_return();
    logic       exp_fv;
    logic [1:0] exp_src;
    for (int i = 46; i <= 54; i++) begin
      tick();
      exp_fv  = (t inside {50, 53});
      exp_src = (t >= 53) ? 2'd1 : 2'd0;
      vectors++;
      if (frame_valid !== exp_fv || active_src !== exp_src) begin
        fails++;
        $display("FAIL pre_alert t=%0d got fv=%b src=%0d want fv=%b src=%0d",
                 t, frame_valid, active_src, exp_fv, exp_src);
      end
    end
    alert_req = 1'b1;
    for (int i = 55; i <= 63; i++) begin
      tick();
`ifdef ALERT_BLINK_EN
      exp_fv = (t inside {55, 58, 61, 63});
`else
      exp_fv = (t inside {55, 60, 63});
`endif
      exp_src = (t < 63) ? 2'd2 : 2'd1;
      vectors++;
      if (frame_valid !== exp_fv || active_src !== exp_src) begin
        fails++;
        $display("FAIL alert t=%0d got fv=%b src=%0d want fv=%b src=%0d",
                 t, frame_valid, active_src, exp_fv, exp_src);
      end
      if (t == 55 || t == 63) begin
        vectors++;
        if ({line1, line2} !== ((t == 55) ? ALERT : P1)) begin
          fails++;
          $display("FAIL alert_frame t=%0d got %h", t, {line1, line2});
        end
      end
`ifdef ALERT_BLINK_EN
      if (t == 58) begin
        vectors++;
        if ({line1, line2} !== BLANK) begin
          fails++;
          $display("FAIL blink_off t=%0d got %h want %h", t, {line1, line2}, BLANK);
        end
      end
`endif
      if (t == 57) alert_req = 1'b0;
    end
  endtask

  task automatic test_alert_on_dwell();
    logic       exp_fv;
    logic [1:0] exp_src;
    for (int i = 64; i <= 78; i++) begin
      tick();
      exp_fv  = (t inside {68, 71, 76});
      exp_src = (t < 71) ? 2'd1 : 2'd0;
      vectors++;
      if (frame_valid !== exp_fv || active_src !== exp_src) begin
        fails++;
        $display("FAIL pre_dwell t=%0d got fv=%b src=%0d want fv=%b src=%0d",
                 t, frame_valid, active_src, exp_fv, exp_src);
      end
    end
    // Cycle 78 is the dwell-expiry cycle of page 0; the alert must win.
    alert_req = 1'b1;
    tick();
    alert_req = 1'b0;
    vectors++;
    if (frame_valid !== 1'b1 || active_src !== 2'd2) begin
      fails++;
      $display("FAIL alert_vs_dwell t=%0d got fv=%b src=%0d want fv=1 src=2", t, frame_valid, active_src);
    end
    for (int i = 80; i <= 85; i++) begin
      tick();
`ifdef ALERT_BLINK_EN
      exp_fv = (t inside {82, 85});
`else
      exp_fv = (t inside {84, 85});
`endif
      exp_src = (t < 85) ? 2'd2 : 2'd0;
      vectors++;
      if (frame_valid !== exp_fv || active_src !== exp_src) begin
        fails++;
        $display("FAIL dwell_alert_hold t=%0d got fv=%b src=%0d want fv=%b src=%0d",
                 t, frame_valid, active_src, exp_fv, exp_src);
      end
    end
    vectors++;
    if ({line1, line2} !== P0B) begin
      fails++;
      $display("FAIL return_page0 t=%0d got %h want %h", t, {line1, line2}, P0B);
    end
  endtask

  task automatic test_reset_mid_alert();
    alert_req = 1'b1;
    tick();
    vectors++;
    if (frame_valid !== 1'b1 || active_src !== 2'd2 || {line1, line2} !== ALERT) begin
      fails++;
      $display("FAIL mid_alert_entry t=%0d got fv=%b src=%0d", t, frame_valid, active_src);
    end
    #2;
    rst_n = 1'b0;
    #1;
    vectors++;
    if ({line1, line2} !== BLANK || active_src !== 2'd3 || frame_valid !== 1'b0) begin
      fails++;
      $display("FAIL async_reset got fv=%b src=%0d lines=%h want fv=0 src=3 blank",
               frame_valid, active_src, {line1, line2});
    end
    tick();
    rst_n = 1'b1;
    repeat (3) tick();
    vectors++;
    if (frame_valid !== 1'b0 || active_src !== 2'd3) begin
      fails++;
      $display("FAIL reinit_wait got fv=%b src=%0d want fv=0 src=3", frame_valid, active_src);
    end
    tick();
    vectors++;
    if (frame_valid !== 1'b1 || active_src !== 2'd2 || {line1, line2} !== ALERT) begin
      fails++;
      $display("FAIL init_to_alert got fv=%b src=%0d want fv=1 src=2 alert", frame_valid, active_src);
    end
    alert_req = 1'b0;
  endtask

  initial begin
    test_reset();
    test_free_run();
    test_hold();
    test_alert_return();
    test_alert_on_dwell();
    test_reset_mid_alert();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog simulation did not complete in time");
    $fatal(1, "watchdog expired");
  end

endmodule
